hc02_tester: RTL and testbench

Self-checking exerciser for a quad 2-input NOR device (74HC02 footprint), driven from the FPGA. On START it drives all 256 combinations of the A[4:1]/B[4:1] inputs into the device under test. It reads the Y[4:1] pins back through a synchronizer and compares each vector against the ideal NOR. It then reports pass/fail, the error count, per-gate fail flags and the first failing vector. It sits at the opposite end of the gate interface, in the same 74-series bring-up/lab design as the gate models.

---
 rtl/hc_pkg.sv | 14 +
 rtl/hc_sync2.sv | 25 ++
 rtl/hc02_tester.sv | 131 +++++++++++++
 tb/tb_hc02_tester.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/hc_pkg.sv
// Shared types and constants for the 74HC02 pin-level tester.
// The synchronizer and the tester top both import this package.
package hc_pkg;
  localparam int VEC_W       = 8;
  localparam int GATES       = 4;
  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CHECK,
    FINISH
  } state_t;
endpackage

// File: rtl/hc_sync2.sv
// Multi-bit flop-chain synchronizer for pin readback from a device that is
// asynchronous to clk. Each bit is synchronized on its own.
module hc_sync2
  import hc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [GATES-1:0] i_d,
  output logic [GATES-1:0] o_q
);

  logic [SYNC_STAGES-1:0][GATES-1:0] r_sync;

  // NOTE: non-blocking assignment makes each stage capture the previous stage's old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/hc02_tester.sv
// Exhaustive tester for a quad 2-input NOR device: it sweeps all 256 A/B
// patterns, compares the synchronized Y pins against ideal NOR and reports the results.
module hc02_tester
  import hc_pkg::*;
#(
  parameter int SETTLE_CYCLES = 3
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       START,
  output logic [4:1] A_OUT,
  output logic [4:1] B_OUT,
  input  logic [4:1] Y_IN,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [8:0] ERR_CNT,
  output logic [4:1] FAIL_GATE,
  output logic [7:0] FIRST_FAIL_VEC
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES);

  generate
    if (SETTLE_CYCLES < 3) begin : g_bad_settle
      $error("hc02_tester: SETTLE_CYCLES must be >= 3");
    end
  endgenerate

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_settle_cnt;
  logic [VEC_W-1:0] r_vec;
  logic [VEC_W-1:0] w_vec_inc;
  logic [GATES:1]   w_y_s;
  logic [GATES:1]   w_mismatch;
  logic             w_any_fail;
  logic             w_settle_done;
  logic             w_last_vec;
  logic [8:0]       w_err_next;

  hc_sync2 u_sync (
    .clk   (CLK),
    .rst_n (RST_N),
    .i_d   (Y_IN),
    .o_q   (w_y_s)
  );

  // Compare only in CHECK, when the pins have had SETTLE_CYCLES to propagate.
  assign w_mismatch    = (r_state == CHECK) ? (w_y_s ^ ~(A_OUT | B_OUT)) : '0;
  assign w_any_fail    = |w_mismatch;
  assign w_settle_done = (r_settle_cnt == CNT_W'(SETTLE_CYCLES - 1));
  assign w_last_vec    = (r_vec == '1);
  assign w_vec_inc     = r_vec + VEC_W'(1);
  assign w_err_next    = ERR_CNT + 9'(w_any_fail);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: the default assignment at the top of always_comb prevents latch inference.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (START) w_state_next = SETTLE;
      SETTLE:  if (w_settle_done) w_state_next = CHECK;
      CHECK:   w_state_next = w_last_vec ? FINISH : SETTLE;
      FINISH:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    BUSY = (r_state == SETTLE) || (r_state == CHECK);
    DONE = (r_state == FINISH);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_settle_cnt   <= '0;
      r_vec          <= '0;
      A_OUT          <= '0;
      B_OUT          <= '0;
      PASS           <= 1'b0;
      ERR_CNT        <= '0;
      FAIL_GATE      <= '0;
      FIRST_FAIL_VEC <= '0;
    end else begin
      r_settle_cnt <= (r_state == SETTLE) ? r_settle_cnt + CNT_W'(1) : '0;
      case (r_state)
        IDLE: begin
          if (START) begin
            r_vec          <= '0;
            A_OUT          <= '0;
            B_OUT          <= '0;
            PASS           <= 1'b0;
            ERR_CNT        <= '0;
            FAIL_GATE      <= '0;
            FIRST_FAIL_VEC <= '0;
          end
        end
        CHECK: begin
          if (w_any_fail) begin
            FAIL_GATE <= FAIL_GATE | w_mismatch;
            ERR_CNT   <= w_err_next;
            if (ERR_CNT == '0) FIRST_FAIL_VEC <= r_vec;
          end
          // PASS uses the post-update count so it is already valid in the DONE cycle.
          if (w_last_vec) begin
            PASS <= (w_err_next == '0);
          end else begin
            r_vec <= w_vec_inc;
            A_OUT <= w_vec_inc[3:0];
            B_OUT <= w_vec_inc[7:4];
          end
        end
        FINISH: begin
          r_vec <= '0;
          A_OUT <= '0;
          B_OUT <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hc02_tester.sv
// Bench for hc02_tester: fault-injecting NOR device models and a vector-sweep
// reference that predicts the error count, gate flags and first failing vector.
module tb_hc02_tester;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start3 = 1'b0, start4 = 1'b0;
  logic [4:1] a3, b3, y3, a4, b4, y4;
  logic       busy3, done3, pass3, busy4, done4, pass4;
  logic [8:0] err3, err4;
  logic [4:1] fg3, fg4;
  logic [7:0] ffv3, ffv4;
  logic [7:0] modes = 8'h00;
  logic [4:1] d1, d2;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int         err;
    logic [4:1] fg;
    logic [7:0] ffv;
  } result_t;

  // Per-gate mode in modes[2(n-1)+:2]: 0 ideal, 1 stuck-0, 2 stuck-1, 3 OR.
  function automatic logic [4:1] dev_model(input logic [4:1] a, input logic [4:1] b,
                                           input logic [7:0] m);
    logic [4:1] y;
    for (int n = 1; n <= 4; n++) begin
      case (m[2*(n-1) +: 2])
        2'd0:    y[n] = ~(a[n] | b[n]);
        2'd1:    y[n] = 1'b0;
        2'd2:    y[n] = 1'b1;
        default: y[n] = a[n] | b[n];
      endcase
    end
    return y;
  endfunction

  function automatic result_t ref_run(input logic [7:0] m);
    result_t    r;
    logic [7:0] vv;
    logic [4:1] a, b, diff;
    r.err = 0;
    r.fg  = '0;
    r.ffv = '0;
    for (int v = 0; v < 256; v++) begin
      vv   = 8'(v);
      a    = vv[3:0];
      b    = vv[7:4];
      diff = ~(a | b) ^ dev_model(a, b, m);
      if (diff != '0) begin
        if (r.err == 0) r.ffv = vv;
        r.err++;
        r.fg |= diff;
      end
    end
    return r;
  endfunction

  assign y3 = dev_model(a3, b3, modes);

  always @(posedge clk) begin
    d1 <= ~(a4 | b4);
    d2 <= d1;
  end
  assign y4 = d2;

  hc02_tester #(.SETTLE_CYCLES(3)) dut (
    .CLK(clk), .RST_N(rst_n), .START(start3), .A_OUT(a3), .B_OUT(b3), .Y_IN(y3),
    .BUSY(busy3), .DONE(done3), .PASS(pass3), .ERR_CNT(err3), .FAIL_GATE(fg3),
    .FIRST_FAIL_VEC(ffv3)
  );

  hc02_tester #(.SETTLE_CYCLES(4)) dut4 (
    .CLK(clk), .RST_N(rst_n), .START(start4), .A_OUT(a4), .B_OUT(b4), .Y_IN(y4),
    .BUSY(busy4), .DONE(done4), .PASS(pass4), .ERR_CNT(err4), .FAIL_GATE(fg4),
    .FIRST_FAIL_VEC(ffv4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // One full run on the SETTLE_CYCLES=3 instance; cycle 1 is the cycle after START is sampled.
  task automatic run3(input string tag, input logic [7:0] m, input bit repulse);
    result_t exp;
    int      done_cyc, busy_bad, vec_bad, early_done;
    modes      = m;
    exp        = ref_run(m);
    done_cyc   = -1;
    busy_bad   = 0;
    vec_bad    = 0;
    early_done = 0;
    @(negedge clk) start3 = 1'b1;
    for (int c = 1; c <= 1100 && done_cyc < 0; c++) begin
      @(posedge clk); #1;
      start3 = repulse && (c == 50 || c == 700 || c == 1023);
      if (c <= 1024) begin
        if (busy3 !== 1'b1) busy_bad++;
        if ({b3, a3} !== 8'((c - 1) / 4)) vec_bad++;
      end
      if (done3 === 1'b1) begin
        done_cyc = c;
      end
    end
    start3 = 1'b0;
    check({tag, "_done_cycle"}, done_cyc, 1025);
    check({tag, "_busy_run"}, busy_bad, 0);
    check({tag, "_vec_drive"}, vec_bad, 0);
    check({tag, "_busy_at_done"}, busy3, 0);
    check({tag, "_pass"}, pass3, (exp.err == 0));
    check({tag, "_err_cnt"}, err3, exp.err);
    check({tag, "_fail_gate"}, fg3, exp.fg);
    check({tag, "_first_fail"}, ffv3, exp.ffv);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, done3, 0);
    check({tag, "_held"}, {pass3, err3, fg3, ffv3}, {(exp.err == 0), 9'(exp.err), exp.fg, exp.ffv});
    check({tag, "_idle_pins"}, {b3, a3}, 0);
  endtask

  initial begin
    int      done_cyc, seen;
    result_t exp;

    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    check("reset_ctrl", {busy3, done3, pass3, busy4, done4, pass4}, 0);
    check("reset_results", {err3, fg3, ffv3}, 0);
    check("reset_pins", {b3, a3, b4, a4}, 0);

    run3("ideal", 8'h00, 1'b0);
    run3("g3_stuck0", 8'h10, 1'b0);
    run3("g2_stuck1", 8'h08, 1'b0);
    run3("g1_or", 8'h03, 1'b0);
    for (int i = 0; i < 3; i++) run3("random", 8'($urandom), 1'b0);
    run3("repulse", 8'h00, 1'b1);

    // Abort at vector 100 with an always-failing gate so results are non-zero.
    modes = 8'h03;
    @(negedge clk) start3 = 1'b1;
    @(posedge clk); #1 start3 = 1'b0;
    repeat (401) @(posedge clk);
    #1;
    check("mid_err_cnt", err3, 100);
    check("mid_busy", busy3, 1);
    rst_n = 1'b0;
    #1;
    check("abort_ctrl", {busy3, done3, pass3}, 0);
    check("abort_results", {err3, fg3, ffv3}, 0);
    check("abort_pins", {b3, a3}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 1100; c++) begin
      @(posedge clk); #1;
      if (done3 === 1'b1 || busy3 === 1'b1) seen++;
    end
    check("abort_no_done", seen, 0);
    run3("after_abort", 8'h00, 1'b0);

    // START held high re-arms in the IDLE cycle right after FINISH.
    modes = 8'h00;
    @(negedge clk) start3 = 1'b1;
    done_cyc = -1;
    for (int c = 0; c < 1100 && done_cyc < 0; c++) begin
      @(posedge clk); #1;
      if (done3 === 1'b1) done_cyc = c;
    end
    check("rearm_done_seen", (done_cyc >= 0), 1);
    @(posedge clk); #1;
    check("rearm_idle_cycle", busy3, 0);
    @(posedge clk); #1;
    check("rearm_busy", busy3, 1);
    start3 = 1'b0;
    done_cyc = -1;
    for (int c = 0; c < 1100 && done_cyc < 0; c++) begin
      @(posedge clk); #1;
      if (done3 === 1'b1) done_cyc = c;
    end
    check("rearm_second_done", (done_cyc >= 0), 1);
    check("rearm_pass", pass3, 1);

    // Device with a 2-cycle output delay, SETTLE_CYCLES=4.
    exp = ref_run(8'h00);
    @(negedge clk) start4 = 1'b1;
    done_cyc = -1;
    for (int c = 1; c <= 1400 && done_cyc < 0; c++) begin
      @(posedge clk); #1;
      start4 = 1'b0;
      if (done4 === 1'b1) done_cyc = c;
    end
    check("slow_done_cycle", done_cyc, 1281);
    check("slow_pass", pass4, 1);
    check("slow_results", {err4, fg4, ffv4}, {9'(exp.err), exp.fg, exp.ffv});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
